// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between the BRAM FIFO read port, the drain stage and the
// downstream stream consumer.
interface fifo_stream_reader_if #(
  parameter int DIN_WIDTH = 16
);
  logic                 fifo_empty;
  logic [DIN_WIDTH-1:0] fifo_rdata;
  logic                 fifo_r_valid;
  logic                 read_req;
  logic [DIN_WIDTH-1:0] m_tdata;
  logic                 m_tvalid;
  logic                 m_tready;
  logic                 m_tlast;
  logic                 overflow;

  modport master (
    input  fifo_empty, fifo_rdata, fifo_r_valid, m_tready,
    output read_req, m_tdata, m_tvalid, m_tlast, overflow
  );

  modport slave (
    output fifo_empty, fifo_rdata, fifo_r_valid, m_tready,
    input  read_req, m_tdata, m_tvalid, m_tlast, overflow
  );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a 1-cycle-latency BRAM FIFO into a valid/ready stream through a
// 2-entry skid buffer, tagging every FRAME_LEN-th beat with m_tlast.
module fifo_stream_reader #(
  parameter int DIN_WIDTH = 16,
  parameter int FRAME_LEN = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  fifo_stream_reader_if.master bus
);

  localparam int BW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(FRAME_LEN - 1);

  logic [DIN_WIDTH-1:0] head;
  logic [DIN_WIDTH-1:0] tail;
  logic [1:0]           occ;
  logic                 pend;
  logic [BW-1:0]        beat;
  logic                 ovf;

  logic                 pop;
  logic                 push;
  logic [2:0]           credit;
  logic                 req;

  // A read is only issued when the word it returns is guaranteed a slot,
  // counting the pop happening this cycle as freed space.
  always_comb begin
    pop    = (occ != 2'd0) & bus.m_tready;
    push   = bus.fifo_r_valid;
    credit = {1'b0, occ} + {2'b00, pend};
    req    = ~rst & ~bus.fifo_empty & (credit <= (3'd1 + {2'b00, pop}));
  end

  assign bus.read_req = req;
  assign bus.m_tvalid = (occ != 2'd0);
  assign bus.m_tdata  = head;
  assign bus.m_tlast  = (occ != 2'd0) & (beat == LAST_BEAT);
  assign bus.overflow = ovf;

  always_ff @(posedge clk) begin
    if (rst) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
      pend <= 1'b0;
      beat <= '0;
      ovf  <= 1'b0;
    end else begin
      pend <= req;

      case ({push, pop})
        2'b10: begin
          case (occ)
            2'd0: begin
              head <= bus.fifo_rdata;
              occ  <= 2'd1;
            end
            2'd1: begin
              tail <= bus.fifo_rdata;
              occ  <= 2'd2;
            end
            default: ovf <= 1'b1;
          endcase
        end
        2'b01: begin
          head <= tail;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Head leaves, so the new word takes whichever slot becomes the tail.
          if (occ == 2'd1) begin
            head <= bus.fifo_rdata;
          end else begin
            head <= tail;
            tail <= bus.fifo_rdata;
          end
        end
        default: ;
      endcase

      if (pop) begin
        beat <= (beat == LAST_BEAT) ? '0 : beat + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Scoreboard bench for fifo_stream_reader: a behavioural BRAM FIFO feeds the
// DUT, expected beats are queued at write time and checked by a monitor.
module tb_fifo_stream_reader;

  localparam int DW = 16;
  localparam int FL = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_stream_reader_if #(.DIN_WIDTH(DW)) bus ();

  fifo_stream_reader #(.DIN_WIDTH(DW), .FRAME_LEN(FL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int pop_cnt = 0;
  int exp_idx = 0;

  logic [DW-1:0] exp_d[$];
  logic          exp_l[$];

  // Behavioural synchronous FIFO with one-cycle read latency.
  logic [DW-1:0] mem[$];
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          rv_q = 1'b0;
  logic [DW-1:0] rd_q = '0;
  logic          empty_q = 1'b1;
  logic          inj_rv = 1'b0;
  logic [DW-1:0] inj_d = '0;

  assign bus.fifo_empty   = empty_q;
  assign bus.fifo_r_valid = rv_q | inj_rv;
  assign bus.fifo_rdata   = inj_rv ? inj_d : rd_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      mem.delete();
      rv_q    <= 1'b0;
      rd_q    <= '0;
      empty_q <= 1'b1;
    end else begin
      if (bus.read_req && mem.size() > 0) begin
        rd_q <= mem.pop_front();
        rv_q <= 1'b1;
      end else begin
        rv_q <= 1'b0;
      end
      if (wr_en) mem.push_back(wr_data);
      empty_q <= (mem.size() == 0);
    end
  end

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted beat.
  always @(negedge clk) begin
    if (!rst) begin
      chk("read_req_while_empty", bus.read_req & bus.fifo_empty, 0);
      if (bus.m_tvalid && bus.m_tready) begin
        if (exp_d.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got data %0h, expected no beat (cycle %0d)",
                   bus.m_tdata, cyc);
        end else begin
          chk("beat_data", bus.m_tdata, exp_d.pop_front());
          chk("beat_last", bus.m_tlast, exp_l.pop_front());
        end
        pop_cnt++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    exp_d.push_back(d);
    exp_l.push_back((exp_idx % FL) == FL - 1);
    exp_idx++;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while ((exp_d.size() != 0 || bus.m_tvalid) && n < max_cyc) begin
      tick();
      n++;
    end
    chk("drain_timeout", (exp_d.size() != 0 || bus.m_tvalid), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int t_fall;
    int t_val;
    int run;
    int n;

    bus.m_tready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_read_req", bus.read_req, 0);
    chk("rst_tvalid", bus.m_tvalid, 0);
    chk("rst_tlast", bus.m_tlast, 0);
    chk("rst_tdata", bus.m_tdata, 0);
    chk("rst_overflow", bus.overflow, 0);
    rst = 1'b0;
    tick();

    // Basic latency and framing: 0x0001..0x0010 at one per cycle.
    bus.m_tready = 1'b1;
    t_fall = -1;
    t_val = -1;
    fork
      begin
        for (int i = 1; i <= 16; i++) write_word(DW'(i));
      end
      begin
        n = 0;
        while (bus.fifo_empty && n < 40) begin tick(); n++; end
        t_fall = cyc;
        n = 0;
        while (!bus.m_tvalid && n < 40) begin tick(); n++; end
        t_val = cyc;
        chk("first_valid_latency", t_val - t_fall, 2);
        run = 0;
        for (int i = 0; i < 16; i++) begin
          if (bus.m_tvalid) run++;
          tick();
        end
        chk("no_gaps_16_beats", run, 16);
      end
    join
    wait_drain(100);
    chk("basic_overflow", bus.overflow, 0);

    // Backpressure: 20 words queued behind a stalled consumer.
    bus.m_tready = 1'b0;
    for (int i = 0; i < 20; i++) write_word(DW'(i));
    for (int i = 0; i < 10; i++) begin
      chk("bp_tvalid", bus.m_tvalid, 1);
      chk("bp_tdata_stable", bus.m_tdata, 0);
      chk("bp_read_req_low", bus.read_req, 0);
      chk("bp_fifo_level", mem.size(), 18);
      tick();
    end
    bus.m_tready = 1'b1;
    wait_drain(100);
    chk("bp_overflow", bus.overflow, 0);

    // Random ready with 1000 random words.
    for (int i = 0; i < 1000; i++) begin
      bus.m_tready = 1'($urandom_range(0, 1));
      write_word(DW'($urandom));
    end
    n = 0;
    while ((exp_d.size() != 0 || bus.m_tvalid) && n < 5000) begin
      bus.m_tready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    chk("rand_drain_timeout", exp_d.size(), 0);
    bus.m_tready = 1'b1;
    tick();
    chk("rand_overflow", bus.overflow, 0);

    // Empty boundary: framing continues across an idle gap.
    for (int i = 0; i < 6; i++) write_word(DW'(16'h0E00 + i));
    wait_drain(100);
    for (int i = 0; i < 5; i++) begin
      chk("gap_tvalid", bus.m_tvalid, 0);
      chk("gap_tlast", bus.m_tlast, 0);
      tick();
    end
    for (int i = 0; i < 6; i++) write_word(DW'(16'h0E10 + i));
    wait_drain(100);

    // Reset mid-frame with a read in flight.
    n = pop_cnt;
    fork
      begin
        for (int i = 0; i < 12; i++) write_word(DW'(16'h0B00 + i));
      end
      begin
        run = 0;
        while (pop_cnt < n + 4 && run < 60) begin tick(); run++; end
      end
    join_any
    disable fork;
    chk("mid_frame_pops", pop_cnt - n, 4);
    wr_en = 1'b0;
    bus.m_tready = 1'b0;
    rst = 1'b1;
    exp_d.delete();
    exp_l.delete();
    exp_idx = 0;
    #1;
    chk("rst_cycle_read_req", bus.read_req, 0);
    chk("rst_cycle_r_valid_in_flight", bus.fifo_r_valid, 1);
    tick();
    rst = 1'b0;
    chk("post_rst_tvalid", bus.m_tvalid, 0);
    chk("post_rst_tdata", bus.m_tdata, 0);
    chk("post_rst_tlast", bus.m_tlast, 0);
    chk("post_rst_overflow", bus.overflow, 0);
    chk("post_rst_read_req", bus.read_req, 0);
    bus.m_tready = 1'b1;
    repeat (4) tick();
    chk("in_flight_discarded", bus.m_tvalid, 0);
    for (int i = 0; i < 10; i++) write_word(DW'(16'h0A00 + i));
    wait_drain(100);

    // Overflow injection: three forced pushes with no pops.
    bus.m_tready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      inj_rv = 1'b1;
      inj_d  = DW'(16'h0F00 + i);
      tick();
      chk("ovf_after_push", bus.overflow, (i == 2) ? 1 : 0);
    end
    inj_rv = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("ovf_sticky", bus.overflow, 1);
      chk("ovf_head_kept", bus.m_tdata, 16'h0F00);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ovf_cleared_by_rst", bus.overflow, 0);
    chk("ovf_rst_tvalid", bus.m_tvalid, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
